// File: rtl/ahim_config_pkg.sv
// Shared AHIM constants: PIO command codes, PIO_STATUS bit positions and the
// host-driver state and error encodings.
package ahim_config_pkg;

  localparam int CMD_IDLE  = 0;
  localparam int CMD_LOAD  = 1;
  localparam int CMD_READ  = 2;
  localparam int CMD_CLEAR = 3;

  // Bit positions inside PIO_STATUS, matching build_status
  localparam int ST_WAITREQ_OUT  = 0;
  localparam int ST_WAITREQ_IN   = 1;
  localparam int ST_BUSY         = 2;
  localparam int ST_RESULT_READY = 3;
  localparam int ST_ERROR        = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_LOAD_CMD,
    S_WRITE,
    S_POLL,
    S_RD_CMD,
    S_READ,
    S_FIN,
    S_ABORT
  } ahim_host_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_STATUS  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ZERO    = 2'd3
  } ahim_host_err_t;

endpackage

// File: rtl/ahim_host_watchdog.sv
// Stall counter for the host driver: counts consecutive stall cycles while
// enabled and flags the cycle on which the TIMEOUT-th stall occurs.
module ahim_host_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk_in,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  // cnt holds the number of earlier stall cycles, so the current one is the
  // (cnt+1)-th; leaving a counting state drops it back to zero.
  always_ff @(posedge clk_in) begin
    if (rst || !en || clear)
      cnt <= '0;
    else if (cnt != TW'(TIMEOUT - 1))
      cnt <= cnt + TW'(1);
  end

  assign expired = en && !clear && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/ahim_host_driver.sv
// FPGA-side AHIM host initiator: clear, load, stream image words, poll status,
// then drain result words, mirroring the HPS software sequence.
module ahim_host_driver
  import ahim_config_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int STATUS_W = 64,
  parameter int CMD_W    = 8,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 65535
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    wr_words,
  input  logic [CNT_W-1:0]    rd_words,
  input  logic                src_valid,
  input  logic [DATA_W-1:0]   src_data,
  output logic                src_ready,
  output logic                snk_valid,
  output logic [DATA_W-1:0]   snk_data,
  output logic [CMD_W-1:0]    PIO_CMD,
  output logic [DATA_W-1:0]   PIO_OUT,
  output logic                write_request,
  input  logic                waitrequest_out,
  input  logic [DATA_W-1:0]   PIO_IN,
  output logic                read_request,
  input  logic                waitrequest_in,
  input  logic [STATUS_W-1:0] PIO_STATUS,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code
);

  ahim_host_state_t state;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             wr_beat;
  logic             rd_beat;
  logic             wd_en;
  logic             wd_clear;
  logic             wd_expired;
  logic             st_err;
  logic             st_rdy;
  logic             st_busy;
  logic             unused_status;

  assign st_err  = PIO_STATUS[ST_ERROR];
  assign st_rdy  = PIO_STATUS[ST_RESULT_READY];
  assign st_busy = PIO_STATUS[ST_BUSY];
  assign unused_status = ^{PIO_STATUS[STATUS_W-1:ST_ERROR+1], PIO_STATUS[ST_BUSY-1:0]};

  // Write side is combinational so a source word can be taken every cycle.
  assign write_request = (state == S_WRITE) && src_valid;
  assign PIO_OUT       = (state == S_WRITE) ? src_data : '0;
  assign src_ready     = write_request && !waitrequest_out;

  assign wr_beat  = src_ready;
  assign rd_beat  = (state == S_READ) && read_request && !waitrequest_in;
  assign wd_en    = (state == S_WRITE) || (state == S_POLL) || (state == S_READ);
  assign wd_clear = wr_beat || rd_beat;

  ahim_host_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (wd_en),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= S_IDLE;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      PIO_CMD      <= CMD_W'(CMD_IDLE);
      read_request <= 1'b0;
      snk_valid    <= 1'b0;
      snk_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      snk_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            wr_cnt <= wr_words;
            rd_cnt <= rd_words;
            if (wr_words == '0) begin
              err      <= 1'b1;
              err_code <= ERR_ZERO;
            end else begin
              err_code <= ERR_NONE;
              busy     <= 1'b1;
              PIO_CMD  <= CMD_W'(CMD_CLEAR);
              state    <= S_CLR;
            end
          end
        end
        S_CLR: begin
          PIO_CMD <= CMD_W'(CMD_LOAD);
          state   <= S_LOAD_CMD;
        end
        S_LOAD_CMD: begin
          PIO_CMD <= CMD_W'(CMD_IDLE);
          state   <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_beat) begin
            wr_cnt <= wr_cnt - CNT_W'(1);
            if (wr_cnt == CNT_W'(1))
              state <= S_POLL;
          end else if (wd_expired) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            PIO_CMD  <= CMD_W'(CMD_CLEAR);
            state    <= S_ABORT;
          end
        end
        S_POLL: begin
          // A reported error wins over result_ready seen in the same cycle.
          if (st_err) begin
            err      <= 1'b1;
            err_code <= ERR_STATUS;
            PIO_CMD  <= CMD_W'(CMD_CLEAR);
            state    <= S_ABORT;
          end else if (st_rdy && !st_busy) begin
            if (rd_cnt == '0) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              PIO_CMD <= CMD_W'(CMD_READ);
              state   <= S_RD_CMD;
            end
          end else if (wd_expired) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            PIO_CMD  <= CMD_W'(CMD_CLEAR);
            state    <= S_ABORT;
          end
        end
        S_RD_CMD: begin
          PIO_CMD      <= CMD_W'(CMD_IDLE);
          read_request <= 1'b1;
          state        <= S_READ;
        end
        S_READ: begin
          if (rd_beat) begin
            rd_cnt    <= rd_cnt - CNT_W'(1);
            snk_valid <= 1'b1;
            snk_data  <= PIO_IN;
            if (rd_cnt == CNT_W'(1)) begin
              read_request <= 1'b0;
              done         <= 1'b1;
              state        <= S_FIN;
            end
          end else if (wd_expired) begin
            read_request <= 1'b0;
            err          <= 1'b1;
            err_code     <= ERR_TIMEOUT;
            PIO_CMD      <= CMD_W'(CMD_CLEAR);
            state        <= S_ABORT;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ABORT: begin
          PIO_CMD <= CMD_W'(CMD_IDLE);
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahim_host_driver.sv
// Directed bench for ahim_host_driver against a small AHIM port model with a
// word source, a delayed result_ready and an optional error flag.
module tb_ahim_host_driver;
  import ahim_config_pkg::*;

  localparam int DW = 64, SW = 64, CW = 8, NW = 16, TO = 16;
  localparam logic [DW-1:0] SBASE = 64'hA5A5_0000_0000_0000;
  localparam logic [DW-1:0] RBASE = 64'h5A5A_0000_0000_0000;

  logic clk_in = 1'b0;
  logic rst, start, src_valid, waitrequest_out;
  logic [NW-1:0] wr_words, rd_words;
  logic [DW-1:0] src_data, PIO_IN, PIO_OUT, snk_data;
  logic src_ready, snk_valid, write_request, read_request, waitrequest_in;
  logic busy, done, err;
  logic [CW-1:0] PIO_CMD;
  logic [SW-1:0] PIO_STATUS;
  logic [1:0] err_code;

  always #5 clk_in = ~clk_in;

  ahim_host_driver #(.DATA_W(DW), .STATUS_W(SW), .CMD_W(CW), .CNT_W(NW), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .wr_words(wr_words), .rd_words(rd_words),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_data(snk_data), .PIO_CMD(PIO_CMD), .PIO_OUT(PIO_OUT),
    .write_request(write_request), .waitrequest_out(waitrequest_out), .PIO_IN(PIO_IN),
    .read_request(read_request), .waitrequest_in(waitrequest_in), .PIO_STATUS(PIO_STATUS),
    .busy(busy), .done(done), .err(err), .err_code(err_code));

  // AHIM / source model
  int src_idx = 0, rd_idx = 0, status_cnt = 0, wr_target = 0, poll_delay = 10;
  bit stat_en = 0, err_inj = 0, wri_tog = 0, par = 0;
  logic res_rdy;

  always @(posedge clk_in) begin
    if (src_ready) src_idx <= src_idx + 1;
    if (read_request && !waitrequest_in) rd_idx <= rd_idx + 1;
    if (!stat_en || src_idx < wr_target) status_cnt <= 0;
    else if (status_cnt < 1000) status_cnt <= status_cnt + 1;
  end
  always @(posedge clk_in) begin #1 par = ~par; end

  assign src_data       = SBASE + DW'(src_idx);
  assign PIO_IN         = RBASE + DW'(rd_idx);
  assign res_rdy        = stat_en && (src_idx >= wr_target) && (status_cnt >= poll_delay);
  assign waitrequest_in = wri_tog & par;
  always_comb begin
    PIO_STATUS = '0;
    PIO_STATUS[ST_RESULT_READY] = res_rdy;
    PIO_STATUS[ST_ERROR] = res_rdy & err_inj;
  end

  // Monitor, sampled mid-cycle
  int cyc = 0, wr_beats = 0, rd_beats = 0, done_cnt = 0, err_cnt = 0, clr_cmds = 0, rd_cmds = 0;
  int last_rdbeat_cyc = 0, done_cyc = 0, err_cyc = 0;
  int wr_cyc_log [256];
  logic [DW-1:0] wr_log [256];
  logic [DW-1:0] rd_log [256];
  logic [CW-1:0] err_cmd = '0;

  always @(negedge clk_in) begin
    cyc++;
    if (src_ready) begin
      wr_log[wr_beats % 256] = PIO_OUT;
      wr_cyc_log[wr_beats % 256] = cyc;
      wr_beats++;
    end
    if (read_request && !waitrequest_in) last_rdbeat_cyc = cyc;
    if (snk_valid) begin rd_log[rd_beats % 256] = snk_data; rd_beats++; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; err_cmd = PIO_CMD; end
    if (PIO_CMD == CW'(CMD_CLEAR)) clr_cmds++;
    if (PIO_CMD == CW'(CMD_READ)) rd_cmds++;
  end

  int tests = 0, fails = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_start(input logic [NW-1:0] w, input logic [NW-1:0] r, output int st);
    wr_words = w; rd_words = r; start = 1'b1;
    @(negedge clk_in); #1 st = cyc;
    @(posedge clk_in); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1; break; end
      step(1);
    end
  endtask

  task automatic test_reset;
    src_valid = 1'b1; rst = 1'b1;
    step(3);
    tests++; if (PIO_CMD !== CW'(CMD_IDLE)) begin fails++; $display("FAIL rst_pio_cmd got %0d want 0", PIO_CMD); end
    tests++; if (PIO_OUT !== '0) begin fails++; $display("FAIL rst_pio_out got %h want 0", PIO_OUT); end
    tests++; if ({write_request, read_request, src_ready, snk_valid} !== 4'b0) begin fails++; $display("FAIL rst_strobes got %b want 0000", {write_request, read_request, src_ready, snk_valid}); end
    tests++; if ({busy, done, err} !== 3'b0) begin fails++; $display("FAIL rst_flags got %b want 000", {busy, done, err}); end
    tests++; if (snk_data !== '0) begin fails++; $display("FAIL rst_snk_data got %h want 0", snk_data); end
    tests++; if (err_code !== 2'd0) begin fails++; $display("FAIL rst_err_code got %0d want 0", err_code); end
    rst = 1'b0;
    step(1);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_nominal(input string nm);
    int w0, s0, r0, ri0, d0, e0, rc0, st;
    bit ok;
    waitrequest_out = 1'b0; wri_tog = 0; err_inj = 0; src_valid = 1'b1; poll_delay = 10;
    w0 = wr_beats; s0 = src_idx; r0 = rd_beats; ri0 = rd_idx; d0 = done_cnt; e0 = err_cnt; rc0 = rd_cmds;
    wr_target = s0 + 4; stat_en = 1;
    pulse_start(16'd4, 16'd2, st);
    wait_idle(200, ok);
    stat_en = 0;
    tests++; if (!ok) begin fails++; $display("FAIL %s_timeout busy still %b after 200 cycles want 0", nm, busy); end
    tests++; if (wr_beats - w0 !== 4) begin fails++; $display("FAIL %s_wr_beats got %0d want 4", nm, wr_beats - w0); end
    tests++; if (wr_cyc_log[w0 % 256] - st !== 3) begin fails++; $display("FAIL %s_start_latency got %0d want 3", nm, wr_cyc_log[w0 % 256] - st); end
    tests++; if (wr_cyc_log[(w0 + 3) % 256] - wr_cyc_log[w0 % 256] !== 3) begin fails++; $display("FAIL %s_wr_back2back span got %0d want 3", nm, wr_cyc_log[(w0 + 3) % 256] - wr_cyc_log[w0 % 256]); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (wr_log[(w0 + i) % 256] !== SBASE + DW'(s0 + i)) begin fails++; $display("FAIL %s_wr_data[%0d] got %h want %h", nm, i, wr_log[(w0 + i) % 256], SBASE + DW'(s0 + i)); end
    end
    tests++; if (rd_cmds - rc0 !== 1) begin fails++; $display("FAIL %s_cmd_read_cycles got %0d want 1", nm, rd_cmds - rc0); end
    tests++; if (rd_beats - r0 !== 2) begin fails++; $display("FAIL %s_rd_beats got %0d want 2", nm, rd_beats - r0); end
    for (int i = 0; i < 2; i++) begin
      tests++; if (rd_log[(r0 + i) % 256] !== RBASE + DW'(ri0 + i)) begin fails++; $display("FAIL %s_rd_data[%0d] got %h want %h", nm, i, rd_log[(r0 + i) % 256], RBASE + DW'(ri0 + i)); end
    end
    tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL %s_done_pulses got %0d want 1", nm, done_cnt - d0); end
    tests++; if (done_cyc - last_rdbeat_cyc !== 1) begin fails++; $display("FAIL %s_done_latency got %0d want 1", nm, done_cyc - last_rdbeat_cyc); end
    tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL %s_err_pulses got %0d want 0", nm, err_cnt - e0); end
    tests++; if (err_code !== 2'd0) begin fails++; $display("FAIL %s_err_code got %0d want 0", nm, err_code); end
  endtask

  task automatic test_back_pressure;
    int w0, s0, r0, ri0, d0, st;
    bit ok;
    waitrequest_out = 1'b0; wri_tog = 1; err_inj = 0; src_valid = 1'b1; poll_delay = 5;
    w0 = wr_beats; s0 = src_idx; r0 = rd_beats; ri0 = rd_idx; d0 = done_cnt;
    wr_target = s0 + 4; stat_en = 1;
    pulse_start(16'd4, 16'd2, st);
    for (int i = 0; i < 50 && (wr_beats - w0) < 2; i++) step(1);
    waitrequest_out = 1'b1;
    step(3);
    waitrequest_out = 1'b0;
    wait_idle(200, ok);
    stat_en = 0; wri_tog = 0;
    tests++; if (!ok) begin fails++; $display("FAIL bp_timeout busy still %b want 0", busy); end
    tests++; if (wr_beats - w0 !== 4) begin fails++; $display("FAIL bp_src_ready_count got %0d want 4", wr_beats - w0); end
    tests++; if (wr_cyc_log[(w0 + 3) % 256] - wr_cyc_log[w0 % 256] !== 6) begin fails++; $display("FAIL bp_wr_span got %0d want 6", wr_cyc_log[(w0 + 3) % 256] - wr_cyc_log[w0 % 256]); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (wr_log[(w0 + i) % 256] !== SBASE + DW'(s0 + i)) begin fails++; $display("FAIL bp_wr_data[%0d] got %h want %h", i, wr_log[(w0 + i) % 256], SBASE + DW'(s0 + i)); end
    end
    tests++; if (rd_beats - r0 !== 2) begin fails++; $display("FAIL bp_snk_valid_count got %0d want 2", rd_beats - r0); end
    for (int i = 0; i < 2; i++) begin
      tests++; if (rd_log[(r0 + i) % 256] !== RBASE + DW'(ri0 + i)) begin fails++; $display("FAIL bp_rd_data[%0d] got %h want %h", i, rd_log[(r0 + i) % 256], RBASE + DW'(ri0 + i)); end
    end
    tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL bp_done_pulses got %0d want 1", done_cnt - d0); end
    tests++; if (err_code !== 2'd0) begin fails++; $display("FAIL bp_err_code got %0d want 0", err_code); end
  endtask

  task automatic test_status_error;
    int r0, d0, e0, c0, rc0, st;
    bit ok;
    waitrequest_out = 1'b0; src_valid = 1'b1; poll_delay = 3; err_inj = 1;
    r0 = rd_beats; d0 = done_cnt; e0 = err_cnt; c0 = clr_cmds; rc0 = rd_cmds;
    wr_target = src_idx + 2; stat_en = 1;
    pulse_start(16'd2, 16'd2, st);
    wait_idle(100, ok);
    stat_en = 0; err_inj = 0;
    tests++; if (!ok) begin fails++; $display("FAIL sterr_timeout busy still %b want 0", busy); end
    tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL sterr_err_pulses got %0d want 1", err_cnt - e0); end
    tests++; if (err_code !== 2'd1) begin fails++; $display("FAIL sterr_err_code got %0d want 1", err_code); end
    tests++; if (err_cmd !== CW'(CMD_CLEAR)) begin fails++; $display("FAIL sterr_abort_cmd got %0d want 3", err_cmd); end
    tests++; if (clr_cmds - c0 !== 2) begin fails++; $display("FAIL sterr_clear_cycles got %0d want 2", clr_cmds - c0); end
    tests++; if (rd_beats - r0 !== 0) begin fails++; $display("FAIL sterr_rd_beats got %0d want 0", rd_beats - r0); end
    tests++; if (rd_cmds - rc0 !== 0) begin fails++; $display("FAIL sterr_cmd_read got %0d want 0", rd_cmds - rc0); end
    tests++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL sterr_done got %0d want 0", done_cnt - d0); end
  endtask

  // One beat, then starve the source: the 16th stall cycle trips the
  // watchdog and err shows in the cycle right after it.
  task automatic test_timeout;
    int w0, d0, e0, st;
    bit ok;
    waitrequest_out = 1'b0; src_valid = 1'b1; stat_en = 0;
    w0 = wr_beats; d0 = done_cnt; e0 = err_cnt;
    pulse_start(16'd4, 16'd1, st);
    for (int i = 0; i < 50 && (wr_beats - w0) < 1; i++) step(1);
    src_valid = 1'b0;
    wait_idle(100, ok);
    src_valid = 1'b1;
    tests++; if (!ok) begin fails++; $display("FAIL to_timeout busy still %b want 0", busy); end
    tests++; if (wr_beats - w0 !== 1) begin fails++; $display("FAIL to_wr_beats got %0d want 1", wr_beats - w0); end
    tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL to_err_pulses got %0d want 1", err_cnt - e0); end
    tests++; if (err_cyc - wr_cyc_log[w0 % 256] !== 17) begin fails++; $display("FAIL to_err_cycle got %0d want 17", err_cyc - wr_cyc_log[w0 % 256]); end
    tests++; if (err_code !== 2'd2) begin fails++; $display("FAIL to_err_code got %0d want 2", err_code); end
    tests++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL to_done got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_zero_start;
    int w0, e0, st;
    w0 = wr_beats; e0 = err_cnt; src_valid = 1'b1;
    pulse_start(16'd0, 16'd5, st);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL zero_err got %b want 1", err); end
    tests++; if (err_code !== 2'd3) begin fails++; $display("FAIL zero_err_code got %0d want 3", err_code); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy got %b want 0", busy); end
    step(1);
    tests++; if ({err, busy} !== 2'b00) begin fails++; $display("FAIL zero_after got err,busy=%b want 00", {err, busy}); end
    tests++; if (err_code !== 2'd3) begin fails++; $display("FAIL zero_code_hold got %0d want 3", err_code); end
    step(5);
    tests++; if (wr_beats - w0 !== 0) begin fails++; $display("FAIL zero_wr_beats got %0d want 0", wr_beats - w0); end
    tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL zero_err_pulses got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_ignored_start;
    int w0, r0, d0, e0, st, st2;
    bit ok;
    waitrequest_out = 1'b1; src_valid = 1'b1; poll_delay = 2;
    w0 = wr_beats; r0 = rd_beats; d0 = done_cnt; e0 = err_cnt;
    wr_target = src_idx + 3; stat_en = 1;
    pulse_start(16'd3, 16'd1, st);
    step(3);
    pulse_start(16'd0, 16'd0, st2);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ign_busy got %b want 1", busy); end
    tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL ign_err_mid got %0d want 0", err_cnt - e0); end
    waitrequest_out = 1'b0;
    wait_idle(200, ok);
    stat_en = 0;
    tests++; if (!ok) begin fails++; $display("FAIL ign_timeout busy still %b want 0", busy); end
    tests++; if (wr_beats - w0 !== 3) begin fails++; $display("FAIL ign_wr_beats got %0d want 3", wr_beats - w0); end
    tests++; if (rd_beats - r0 !== 1) begin fails++; $display("FAIL ign_rd_beats got %0d want 1", rd_beats - r0); end
    tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL ign_done got %0d want 1", done_cnt - d0); end
    tests++; if (err_code !== 2'd0) begin fails++; $display("FAIL ign_err_code got %0d want 0", err_code); end
  endtask

  task automatic test_reset_mid_read;
    int st;
    bit ok;
    waitrequest_out = 1'b0; src_valid = 1'b1; poll_delay = 2; wri_tog = 0;
    wr_target = src_idx + 2; stat_en = 1;
    pulse_start(16'd2, 16'd8, st);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (read_request === 1'b1) begin ok = 1; break; end
      step(1);
    end
    tests++; if (!ok) begin fails++; $display("FAIL rstrd_reach_read read_request=%b want 1", read_request); end
    step(2);
    rst = 1'b1;
    step(1);
    tests++; if ({write_request, read_request, src_ready, snk_valid} !== 4'b0) begin fails++; $display("FAIL rstrd_strobes got %b want 0000", {write_request, read_request, src_ready, snk_valid}); end
    tests++; if ({busy, done, err} !== 3'b0) begin fails++; $display("FAIL rstrd_flags got %b want 000", {busy, done, err}); end
    tests++; if (PIO_CMD !== CW'(CMD_IDLE)) begin fails++; $display("FAIL rstrd_pio_cmd got %0d want 0", PIO_CMD); end
    tests++; if (snk_data !== '0) begin fails++; $display("FAIL rstrd_snk_data got %h want 0", snk_data); end
    tests++; if (err_code !== 2'd0) begin fails++; $display("FAIL rstrd_err_code got %0d want 0", err_code); end
    rst = 1'b0; stat_en = 0;
    step(1);
    test_nominal("post_rst");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_valid = 1'b0; waitrequest_out = 1'b0;
    wr_words = '0; rd_words = '0;
    test_reset;
    test_nominal("nominal");
    test_back_pressure;
    test_status_error;
    test_timeout;
    test_zero_start;
    test_ignored_start;
    test_reset_mid_read;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
